// File: rtl/row_clear_ctrl.sv
// Line-clear sequencer: scans the board RAM bottom-up, compacts surviving rows downward, zero-fills the top.
// Optional score output enabled by defining ROW_CLEAR_SCORE_EN.
module row_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            rd_en,
  output logic [4:0]      rd_addr,
  input  logic [COLS-1:0] rd_data,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [COLS-1:0] wr_data,
  output logic            busy,
  output logic            done,
  output logic [5:0]      lines_cleared
`ifdef ROW_CLEAR_SCORE_EN
  ,
  output logic [10:0]     score_add
`endif
);

  typedef enum logic [2:0] {IDLE, READ, EVAL, FILL, DONE} state_t;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t          state, state_nx;
  logic [4:0]      r, r_nx, w, w_nx;
  logic [5:0]      k, k_nx, f, f_nx;
  logic            rd_en_nx, wr_en_nx, busy_nx, done_nx;
  logic [4:0]      rd_addr_nx, wr_addr_nx;
  logic [COLS-1:0] wr_data_nx;
  logic [5:0]      lc_nx;
  logic            full;

  assign full = &rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      r             <= '0;
      w             <= '0;
      k             <= '0;
      f             <= '0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
    end else begin
      state         <= state_nx;
      r             <= r_nx;
      w             <= w_nx;
      k             <= k_nx;
      f             <= f_nx;
      rd_en         <= rd_en_nx;
      rd_addr       <= rd_addr_nx;
      wr_en         <= wr_en_nx;
      wr_addr       <= wr_addr_nx;
      wr_data       <= wr_data_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      lines_cleared <= lc_nx;
    end
  end

  // Outputs are computed one state ahead so every port is a plain register.
  always_comb begin
    state_nx   = state;
    r_nx       = r;
    w_nx       = w;
    k_nx       = k;
    f_nx       = f;
    rd_en_nx   = 1'b0;
    rd_addr_nx = rd_addr;
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;
    busy_nx    = busy;
    done_nx    = 1'b0;
    lc_nx      = lines_cleared;
    case (state)
      IDLE: begin
        if (start) begin
          r_nx       = LAST_ROW;
          w_nx       = LAST_ROW;
          k_nx       = '0;
          rd_en_nx   = 1'b1;
          rd_addr_nx = LAST_ROW;
          busy_nx    = 1'b1;
          state_nx   = READ;
        end
      end
      READ: state_nx = EVAL;
      EVAL: begin
        if (full) begin
          k_nx = k + 6'd1;
        end else begin
          if (w != r) begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = w;
            wr_data_nx = rd_data;
          end
          w_nx = w - 5'd1;
        end
        // Row 0 may itself be full, so the exit test uses the updated count.
        if (r != '0) begin
          r_nx       = r - 5'd1;
          rd_en_nx   = 1'b1;
          rd_addr_nx = r - 5'd1;
          state_nx   = READ;
        end else if (k_nx != '0) begin
          f_nx     = k_nx;
          state_nx = FILL;
        end else begin
          state_nx = DONE;
        end
      end
      FILL: begin
        wr_en_nx   = 1'b1;
        wr_addr_nx = 5'(f - 6'd1);
        wr_data_nx = '0;
        f_nx       = f - 6'd1;
        if (f == 6'd1) state_nx = DONE;
      end
      DONE: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        lc_nx    = k;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef ROW_CLEAR_SCORE_EN
  logic [10:0] score_nx;

  always_comb begin
    case (k)
      6'd0:    score_nx = 11'd0;
      6'd1:    score_nx = 11'd40;
      6'd2:    score_nx = 11'd100;
      6'd3:    score_nx = 11'd300;
      default: score_nx = 11'd1200;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              score_add <= '0;
    else if (state == DONE)  score_add <= score_nx;
  end
`else
`endif

endmodule

// File: tb/tb_row_clear_ctrl.sv
// Bench for row_clear_ctrl: board RAM model plus list-based compaction reference.
module tb_row_clear_ctrl;
  localparam int ROWS = 20;
  localparam int COLS = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            rd_en, wr_en, busy, done;
  logic [4:0]      rd_addr, wr_addr;
  logic [COLS-1:0] rd_data = '0;
  logic [COLS-1:0] wr_data;
  logic [5:0]      lines_cleared;
`ifdef ROW_CLEAR_SCORE_EN
  logic [10:0]     score_add;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  row_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .lines_cleared(lines_cleared)
`ifdef ROW_CLEAR_SCORE_EN
    , .score_add(score_add)
`endif
  );

  // Board RAM: 1-cycle synchronous read, independent write, plus a bench load port.
  logic [COLS-1:0] board [ROWS];
  logic            ld_en = 1'b0;
  logic [4:0]      ld_addr = '0;
  logic [COLS-1:0] ld_data = '0;

  always @(posedge clk) begin
    if (rd_en) rd_data <= board[rd_addr];
    if (wr_en) board[wr_addr] <= wr_data;
    if (ld_en) board[ld_addr] <= ld_data;
  end

  logic [COLS-1:0] img [ROWS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_score(input int kk);
    if (kk == 0) return 0;
    if (kk == 1) return 40;
    if (kk == 2) return 100;
    if (kk == 3) return 300;
    return 1200;
  endfunction

  task automatic load_img();
    for (int i = 0; i < ROWS; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 5'(i); ld_data = img[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_lines"}, lines_cleared, 0);
`ifdef ROW_CLEAR_SCORE_EN
    check({tag, "_score"}, score_add, 0);
`endif
  endtask

  // Runs one pass on whatever the RAM currently holds; repulse_at >= 0 re-pulses start mid-pass.
  task automatic run_pass(input string tag, input int repulse_at);
    logic [COLS-1:0] snap [ROWS];
    logic [COLS-1:0] fin [ROWS];
    int              ea[$], wa[$];
    logic [COLS-1:0] ed[$], wd[$];
    int              kk, p, e, de, last_w, nreads, quiet;
    bit              got_done;

    for (int i = 0; i < ROWS; i++) begin
      snap[i] = board[i];
      fin[i]  = '0;
    end
    kk = 0;
    p  = ROWS - 1;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (snap[i] == {COLS{1'b1}}) kk++;
      else begin
        if (p != i) begin ea.push_back(p); ed.push_back(snap[i]); end
        fin[p] = snap[i];
        p--;
      end
    end
    for (int i = kk - 1; i >= 0; i--) begin ea.push_back(i); ed.push_back('0); end

    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    e = 0; de = -1; last_w = -1; nreads = 0; got_done = 0;
    check({tag, "_busy_rise"}, busy, 1);
    while (!got_done && e < 200) begin
      if (rd_en) begin
        check($sformatf("%s_rd_addr%0d", tag, nreads), rd_addr, ROWS - 1 - nreads);
        nreads++;
      end
      if (wr_en) begin wa.push_back(wr_addr); wd.push_back(wr_data); last_w = e; end
      if (done) begin
        got_done = 1; de = e;
      end else begin
        start = (e == repulse_at);
        @(posedge clk); #1; e++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, got_done, 1);
    check({tag, "_done_cycle"}, de + 1, 2 * ROWS + kk + 2);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_nreads"}, nreads, ROWS);
    check({tag, "_lines"}, lines_cleared, kk);
`ifdef ROW_CLEAR_SCORE_EN
    check({tag, "_score"}, score_add, exp_score(kk));
`endif
    check({tag, "_nwrites"}, wa.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      check($sformatf("%s_wa%0d", tag, i), wa[i], ea[i]);
      check($sformatf("%s_wd%0d", tag, i), wd[i], ed[i]);
    end
    if (ea.size() > 0)
      check({tag, "_last_wr_cycle"}, (last_w + 1 <= 2 * ROWS + kk + 1), 1);

    @(posedge clk); #1;
    check({tag, "_done_one"}, done, 0);
    quiet = 0;
    for (int c = 0; c < 2 * ROWS + 6; c++) begin
      @(posedge clk); #1;
      quiet += int'(done) + int'(wr_en) + int'(busy);
    end
    check({tag, "_quiet_after"}, quiet, 0);
    check({tag, "_lines_hold"}, lines_cleared, kk);
    for (int i = 0; i < ROWS; i++)
      check($sformatf("%s_row%0d", tag, i), board[i], fin[i]);
  endtask

  initial begin
    int any_act;

    #12;
    check_outputs_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < ROWS; i++) img[i] = '0;
    load_img();
    run_pass("empty", -1);

    for (int i = 0; i < ROWS; i++) img[i] = '0;
    img[19] = 10'h3FF; img[18] = 10'h155;
    load_img();
    run_pass("one_line", -1);

    for (int i = 0; i < ROWS; i++) img[i] = '0;
    for (int i = 16; i < 20; i++) img[i] = 10'h3FF;
    img[15] = 10'h001;
    load_img();
    run_pass("tetris", -1);

    for (int i = 0; i < ROWS; i++) img[i] = 10'h3FF;
    load_img();
    run_pass("all_full", -1);

    for (int i = 0; i < ROWS; i++) img[i] = '0;
    img[19] = 10'h3FF; img[18] = 10'h155; img[10] = 10'h3FF; img[9] = 10'h2AA;
    load_img();
    run_pass("repulse", 10);

    for (int i = 0; i < ROWS; i++) img[i] = 10'h200 | (10'h001 << (i % 10));
    img[19] = 10'h3FF; img[17] = 10'h3FF;
    load_img();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_act = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      any_act += int'(wr_en) + int'(busy) + int'(done);
    end
    check("rst_abandon", any_act, 0);
    run_pass("after_rst", -1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < ROWS; i++) begin
        if ($urandom_range(0, 2) == 0) img[i] = 10'h3FF;
        else begin
          img[i] = 10'($urandom);
          if (img[i] == 10'h3FF) img[i][$urandom_range(0, 9)] = 1'b0;
        end
      end
      load_img();
      run_pass($sformatf("rand%0d", t), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
